apu_frame_sequencer: RTL

- APU frame counter ($4017 sequencer) that drives the shared length counters, envelopes, linear counters and sweep units.
- Counts CPU cycles and emits one-clk quarter-frame and half-frame strobes in 4-step or 5-step mode.
- Raises the frame IRQ flag, and handles CPU writes to $4017 and status-read IRQ acknowledge.
- It is the timing source behind the length_counter "clock" side: half_pulse gates decrement, $4017 bit 7 controls the mode.

---
 rtl/apu_frame_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/apu_frame_sequencer.sv
// APU frame counter ($4017): divides CPU cycles into quarter/half-frame strobes
// in 4-step or 5-step mode, raises the frame IRQ and handles the delayed reset.
module apu_frame_sequencer #(
  parameter int CNT_W    = 16,
  parameter int STEP1    = 7457,
  parameter int STEP2    = 14913,
  parameter int STEP3    = 22371,
  parameter int STEP4    = 29829,
  parameter int STEP5    = 37281,
  parameter int WR_DELAY = 3
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       cyc_en,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       status_rd,
  output logic       quarter_pulse,
  output logic       half_pulse,
  output logic       irq_flag,
  output logic       mode
);

  localparam int DLY_W = (WR_DELAY < 2) ? 1 : $clog2(WR_DELAY + 1);

  localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(WR_DELAY);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             mode_q, mode_d;
  logic             inh_q, inh_d;
  logic             irq_q, irq_d;
  logic             qp_q, qp_d;
  logic             hp_q, hp_d;
  logic             pend_q, pend_d;
  logic             irq_set;

  always_comb begin
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    mode_d  = mode_q;
    inh_d   = inh_q;
    irq_d   = irq_q;
    pend_d  = pend_q;
    qp_d    = 1'b0;
    hp_d    = 1'b0;
    irq_set = 1'b0;

    if (cyc_en) begin
      // A delay expiry replaces the step compare entirely; a write on the same clk defers it.
      if (pend_q && (dly_q == DLY_ONE) && !wr_en) begin
        cnt_d  = '0;
        dly_d  = '0;
        pend_d = 1'b0;
        qp_d   = mode_q;
        hp_d   = mode_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == S1 || cnt_q == S3) begin
          qp_d = 1'b1;
        end else if (cnt_q == S2) begin
          qp_d = 1'b1;
          hp_d = 1'b1;
        end else if (!mode_q && cnt_q == S4) begin
          qp_d    = 1'b1;
          hp_d    = 1'b1;
          cnt_d   = '0;
          irq_set = !inh_q;
        end else if (mode_q && cnt_q == S5) begin
          qp_d  = 1'b1;
          hp_d  = 1'b1;
          cnt_d = '0;
        end
        if (pend_q) dly_d = dly_q - 1'b1;
      end
    end

    if (status_rd) irq_d = 1'b0;
    if (irq_set)   irq_d = 1'b1;

    if (wr_en) begin
      mode_d = wr_data[7];
      inh_d  = wr_data[6];
      dly_d  = DLY_INIT;
      pend_d = 1'b1;
      if (wr_data[6]) irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cnt_q  <= '0;
      dly_q  <= '0;
      mode_q <= 1'b0;
      inh_q  <= 1'b0;
      irq_q  <= 1'b0;
      qp_q   <= 1'b0;
      hp_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dly_q  <= dly_d;
      mode_q <= mode_d;
      inh_q  <= inh_d;
      irq_q  <= irq_d;
      qp_q   <= qp_d;
      hp_q   <= hp_d;
      pend_q <= pend_d;
    end
  end

  assign quarter_pulse = qp_q;
  assign half_pulse    = hp_q;
  assign irq_flag      = irq_q;
  assign mode          = mode_q;

endmodule
